// File: rtl/extension_signo_pipe.sv
// extension_signo_pipe: pipelined immediate extender for the ID stage.
// Extends an IN_W-bit immediate to OUT_W bits (sign, zero, branch offset
// or upper immediate), then registers the result behind a valid/ready
// handshake with a one-entry skid buffer.
// Optional feature macro: EXT_STATS_EN adds a 16-bit saturating count of
// consumed results on port stat_count.
//
// Handshake: a transfer happens on the input side when in_valid && in_ready
// and on the output side when out_valid && out_ready, both sampled at the
// rising edge of clk. A producer holding in_valid high must keep instr/mode
// stable until accepted; out_valid/oinstr stay stable until consumed or
// flushed. in_ready depends only on the skid register and reset, never on
// out_ready.
module extension_signo_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  instr,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] oinstr
`ifdef EXT_STATS_EN
    ,
    output logic [15:0]      stat_count
`endif
);

    // Parameter sanity: the branch shift must never overflow the output.
    generate
        if (IN_W < 2) begin : g_bad_in_w
            $error("extension_signo_pipe: IN_W must be at least 2");
        end
        if (OUT_W < IN_W + 2) begin : g_bad_out_w
            $error("extension_signo_pipe: OUT_W must be at least IN_W+2");
        end
    endgenerate

    localparam logic [1:0] MODE_SIGN   = 2'b00;
    localparam logic [1:0] MODE_ZERO   = 2'b01;
    localparam logic [1:0] MODE_BRANCH = 2'b10;
    localparam logic [1:0] MODE_UPPER  = 2'b11;

    logic             r_out_valid;
    logic [OUT_W-1:0] r_oinstr;
    logic             r_skid_valid;
    logic [OUT_W-1:0] r_skid_data;

    logic [OUT_W-1:0] w_sext;
    logic [OUT_W-1:0] w_ext;
    logic             w_accept;
    logic             w_consume;

    assign w_sext    = {{(OUT_W-IN_W){instr[IN_W-1]}}, instr};
    assign in_ready  = !r_skid_valid && !reset;
    assign w_accept  = in_valid && in_ready;
    assign w_consume = r_out_valid && out_ready;

    assign out_valid = r_out_valid;
    assign oinstr    = r_oinstr;

    // Select the extended immediate for the current mode.
    always_comb begin
        w_ext = w_sext;
        case (mode)
            MODE_SIGN:   w_ext = w_sext;
            MODE_ZERO:   w_ext = {{(OUT_W-IN_W){1'b0}}, instr};
            MODE_BRANCH: w_ext = w_sext << 2;
            MODE_UPPER:  w_ext = {instr, {(OUT_W-IN_W){1'b0}}};
            default:     w_ext = w_sext;
        endcase
    end

    // Output register and skid register; reset beats flush beats transfers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid  <= 1'b0;
            r_oinstr     <= '0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
        end else if (flush) begin
            // Drop held entries but keep the data registers as they are.
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (w_consume) begin
            if (r_skid_valid) begin
                // in_ready is low here, so no accept can coincide.
                r_oinstr     <= r_skid_data;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_accept) begin
                r_oinstr    <= w_ext;
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_accept) begin
            if (!r_out_valid) begin
                r_oinstr    <= w_ext;
                r_out_valid <= 1'b1;
            end else begin
                // Output is stalled: park the new result behind it.
                r_skid_data  <= w_ext;
                r_skid_valid <= 1'b1;
            end
        end
    end

`ifdef EXT_STATS_EN
    logic [15:0] r_stat_count;

    assign stat_count = r_stat_count;

    // Saturating count of results actually delivered to the consumer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_count <= '0;
        end else if (!flush && w_consume && (r_stat_count != 16'hFFFF)) begin
            r_stat_count <= r_stat_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_extension_signo_pipe.sv
// tb_extension_signo_pipe: bench for extension_signo_pipe.
// Table-driven vectors, hand-written skid/flush/reset sequences and random
// traffic, all checked against a FIFO-level reference model. Build with
// +define+EXT_STATS_EN to also cover stat_count.
module tb_extension_signo_pipe;

  localparam int IN_W  = 16;
  localparam int OUT_W = 32;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  instr;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] oinstr;
`ifdef EXT_STATS_EN
  logic [15:0]      stat_count;
`endif

  extension_signo_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .mode      (mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .oinstr    (oinstr)
`ifdef EXT_STATS_EN
    ,
    .stat_count(stat_count)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [OUT_W-1:0] exp_q[$];      // results held by the block, oldest first
  logic [OUT_W-1:0] exp_shown;     // value the output register should show
  int               exp_stat;
  int               n_pass;
  int               n_total;

  typedef struct {
    logic [1:0]       mode;
    logic [IN_W-1:0]  instr;
    logic [OUT_W-1:0] expect_v;
  } vec_t;

  vec_t vecs[10];

  // Reference extension computed with plain signed arithmetic.
  function automatic logic [OUT_W-1:0] ref_ext(input logic [1:0] md, input logic [IN_W-1:0] ins);
    longint s;
    longint u;
    longint r;
    longint modv;
    u = longint'(ins);
    s = u;
    if (u >= (longint'(1) << (IN_W - 1))) s = u - (longint'(1) << IN_W);
    case (md)
      2'd0:    r = s;
      2'd1:    r = u;
      2'd2:    r = s * 4;
      default: r = u * (longint'(1) << (OUT_W - IN_W));
    endcase
    modv = longint'(1) << OUT_W;
    r = ((r % modv) + modv) % modv;
    return r[OUT_W-1:0];
  endfunction

  task automatic chk(input string name, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drives one cycle of inputs, checks in_ready,
  // advances the model across the rising edge and checks the outputs at the
  // next falling edge.
  task automatic step(input logic v, input logic [IN_W-1:0] ins, input logic [1:0] md,
                      input logic ordy, input logic fl, input logic rst);
    logic exp_rdy;
    logic acc;
    logic cons;
    in_valid  = v;
    instr     = ins;
    mode      = md;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    #1;
    exp_rdy = (exp_q.size() < 2) && !rst;
    chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
    acc  = v && exp_rdy;
    cons = (exp_q.size() > 0) && ordy;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      exp_shown = '0;
      exp_stat  = 0;
    end else if (fl) begin
      exp_q.delete();
    end else begin
      if (cons) begin
        void'(exp_q.pop_front());
        if (exp_stat < 16'hFFFF) exp_stat++;
      end
      if (acc) exp_q.push_back(ref_ext(md, ins));
      if (exp_q.size() > 0) exp_shown = exp_q[0];
    end
    @(negedge clk);
    chk("out_valid", {31'd0, out_valid}, {31'd0, (exp_q.size() > 0)});
    chk("oinstr", oinstr, exp_shown);
`ifdef EXT_STATS_EN
    chk("stat_count", {16'd0, stat_count}, exp_stat[OUT_W-1:0]);
`endif
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, '0, 2'b00, ordy, 1'b0, 1'b0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    n_pass    = 0;
    n_total   = 0;
    exp_stat  = 0;
    exp_shown = '0;
    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    instr     = '0;
    mode      = 2'b00;
    out_ready = 1'b0;

    vecs[0] = '{2'b00, 16'hFFFF, 32'hFFFFFFFF};
    vecs[1] = '{2'b00, 16'h7FFF, 32'h00007FFF};
    vecs[2] = '{2'b01, 16'h8000, 32'h00008000};
    vecs[3] = '{2'b10, 16'hFFFF, 32'hFFFFFFFC};
    vecs[4] = '{2'b10, 16'h0004, 32'h00000010};
    vecs[5] = '{2'b11, 16'h1234, 32'h12340000};
    vecs[6] = '{2'b01, 16'hFFFF, 32'h0000FFFF};
    vecs[7] = '{2'b11, 16'hFFFF, 32'hFFFF0000};
    vecs[8] = '{2'b10, 16'h8000, 32'hFFFE0000};
    vecs[9] = '{2'b10, 16'h7FFF, 32'h0001FFFC};

    @(negedge clk);
    // Reset: two cycles held, then explicit reset-state checks.
    step(1'b0, '0, 2'b00, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 2'b00, 1'b0, 1'b0, 1'b1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_oinstr", oinstr, 32'd0);

    // Back-to-back vectors with out_ready=1: each result one cycle after
    // accept, out_valid staying high throughout.
    for (int i = 0; i < 10; i++) begin
      step(1'b1, vecs[i].instr, vecs[i].mode, 1'b1, 1'b0, 1'b0);
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_data", i), oinstr, vecs[i].expect_v);
    end
    idle(1'b1);
    chk("drain_valid", {31'd0, out_valid}, 32'd0);
    chk("drain_hold", oinstr, 32'h0001FFFC);

    // Skid: stall the consumer, push two, then present a third while full.
    step(1'b1, 16'h0001, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0002, 2'b00, 1'b0, 1'b0, 1'b0);
    #1;
    chk("skid_full_rdy", {31'd0, in_ready}, 32'd0);
    chk("skid_head", oinstr, 32'h00000001);
    #0;
    @(negedge clk);
    step(1'b1, 16'h0003, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("skid_second", oinstr, 32'h00000002);
    chk("skid_second_v", {31'd0, out_valid}, 32'd1);
    step(1'b0, '0, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("skid_empty_v", {31'd0, out_valid}, 32'd0);
    #1;
    chk("skid_rdy_back", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // Flush with both entries full and a new input offered.
    step(1'b1, 16'h0011, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0022, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h00AA, 2'b00, 1'b0, 1'b1, 1'b0);
    chk("flush_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_keep", oinstr, 32'h00000011);
    #1;
    chk("flush_rdy", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    idle(1'b1);
    idle(1'b1);
    chk("flush_no_aa", {31'd0, out_valid}, 32'd0);

    // Reset while holding a valid result.
    step(1'b1, 16'h5555, 2'b01, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h6666, 2'b01, 1'b0, 1'b0, 1'b1);
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_oinstr", oinstr, 32'd0);
    idle(1'b1);

`ifdef EXT_STATS_EN
    // Three delivered results, then one held entry flushed.
    step(1'b1, 16'h0101, 2'b00, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'h0202, 2'b00, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'h0303, 2'b00, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    step(1'b1, 16'h0404, 2'b00, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 2'b00, 1'b1, 1'b1, 1'b0);
    chk("stat_three", {16'd0, stat_count}, 32'd3);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0),
           IN_W'($urandom),
           2'($urandom_range(0, 3)),
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 29) == 0),
           1'($urandom_range(0, 249) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
